mc_controller: RTL
==================

# mc_controller

Multi-cycle control unit for the word-addressed MIPS-subset CPU. It sequences a multi-cycle datapath that has a shared instruction/data memory, an IR, A/B/ALUOut/MDR registers and a single ALU. It decodes `opc`/`func` from the IR and the ALU `zero` flag into per-cycle Moore control outputs. It also provides start/halt handshaking, illegal-instruction trapping and a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32, width of `instr_count`.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-low reset; sampled on `clk` rising edge, `rst`=0 resets.
- `start` in 1: leave IDLE and begin fetching at the current PC.
- `halt_req` in 1: stop in IDLE after the current instruction completes.
- `opc` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load when `zero`=1.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1, `mem_write` out 1: memory strobes.
- `ir_write` out 1: IR load.
- `reg_write` out 1: register-file write.
- `reg_dst` out 2: write register select; 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: write data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = constant 1, 10 = sign-extended imm16, 11 unused.
- `alu_op` out 3: 000 and, 001 or, 010 add, 110 sub, 111 slt (signed).
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:26], IR[25:0]}, 11 = A.
- `busy` out 1: state is neither IDLE nor HALT.
- `instr_done` out 1: high during the final cycle of each instruction.
- `illegal` out 1: sticky trap flag.
- `instr_count` out CNT_W: count of completed instructions.

## Operation
- Registered 4-bit state. All control outputs are a pure function of the state plus `opc`/`func`/`zero` where noted. Any output not listed for a state is 0.
- **IDLE (0):** all controls 0. `start`=1 → FETCH.
- **FETCH (1):** `mem_read`, `ir_write`, `alu_src_b`=01, `alu_op`=010, `pc_source`=00, `pc_write`. Performs PC ← PC+1. → DECODE.
- **DECODE (2):** `alu_src_b`=10, `alu_op`=010, so ALUOut ← PC+1+imm (branch target). Next state by `opc`:
  - lw 100011 / sw 101011 → MEM_ADDR
  - 000000 → R_EXEC if `func` ∈ {add 100000, sub 100010, and 100100, or 100101, slt 101010}; → JR if `func`=001000; else → HALT
  - addi 001000 / slti 001010 → I_EXEC
  - beq 000100 → BRANCH
  - j 000010 → JUMP
  - jal 000011 → JAL
  - anything else → HALT
- **MEM_ADDR (3):** `alu_src_a`=1, `alu_src_b`=10, add. → MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ (4):** `i_or_d`=1, `mem_read`. → MEM_WB.
- **MEM_WB (5):** `reg_write`, `reg_dst`=00, `mem_to_reg`=01.
- **MEM_WRITE (6):** `i_or_d`=1, `mem_write`.
- **R_EXEC (7):** `alu_src_a`=1, `alu_src_b`=00, `alu_op` from `func` (add 010, sub 110, and 000, or 001, slt 111). → R_WB.
- **R_WB (8):** `reg_write`, `reg_dst`=01, `mem_to_reg`=00.
- **I_EXEC (9):** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=010 for addi, 111 for slti. → I_WB.
- **I_WB (10):** `reg_write`, `reg_dst`=00, `mem_to_reg`=00.
- **BRANCH (11):** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=110, `pc_write_cond`, `pc_source`=01.
- **JUMP (12):** `pc_write`, `pc_source`=10.
- **JAL (13):** `pc_write`, `pc_source`=10, `reg_write`, `reg_dst`=10, `mem_to_reg`=10. Writes PC+1 to $31 and loads the target in the same edge.
- **JR (14):** `pc_write`, `pc_source`=11.
- **HALT (15):** all controls 0, `illegal`=1. Only `rst` leaves this state.
- Final states are MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP, JAL and JR. In each:
  - `instr_done`=1.
  - `instr_count` increments on the leaving edge and wraps modulo 2^CNT_W.
  - Next state is IDLE if `halt_req`=1 in that cycle, else FETCH.
- `halt_req` is ignored in every other state; an instruction in progress always completes.
- `start` is ignored outside IDLE. If `start` and `halt_req` are both 1 in IDLE → FETCH, and the halt takes effect after that instruction.

## Timing
- Cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, j, jal, jr 3.
- `start` sampled in IDLE at edge N → FETCH in cycle N+1.
- Illegal opcode/func detected in DECODE → HALT on the next edge, `illegal`=1 from that cycle on. No register or memory write occurs for the illegal instruction.
- Reset: `rst`=0 at any edge, including mid-instruction or in HALT, forces the following after that edge:
  - state IDLE
  - all controls 0
  - `busy`=0, `instr_done`=0, `illegal`=0, `instr_count`=0
- Outputs are Moore decodes and never glitch-depend on `start` or `halt_req`. `zero` affects the PC only through the datapath's `pc_write_cond` gating.

## Test plan
- Reset, then `start` pulse; program `addi $1,$0,5; add $2,$1,$1; sw $2,0($0); lw $3,0($0)` → $2=10, $3=10, mem[0]=10; `instr_count`=4 after 4+4+4+5=17 cycles from first FETCH.
- beq with $1=$2 and imm=+3 at PC 4 → PC=8 after 3 cycles; with $1≠$2 → PC=5, `pc_write_cond` high only in BRANCH.
- jal at PC 10 with target 40 → $31=11, PC=40; then `jr $31` → PC=11.
- opc 111111 fetched → HALT after DECODE, `illegal`=1, `busy`=0, no `reg_write`/`mem_write` pulse; `start` has no effect until `rst`=0.
- `halt_req` asserted during R_EXEC → R_WB completes, `instr_done`=1, then IDLE; `rst`=0 asserted mid-lw (MEM_READ) → next cycle IDLE with all outputs 0 and `instr_count`=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle control unit for the word-addressed MIPS-subset CPU: Moore control decode,
// start/halt handshaking, illegal-instruction trap and retired-instruction counter.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic [5:0]       opc,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             r_func_ok;

    // zero only gates the PC inside the datapath; the controller never looks at it.
    logic unused_zero;
    assign unused_zero = zero;

    assign r_func_ok = (func == FN_ADD) || (func == FN_SUB) || (func == FN_AND) ||
                       (func == FN_OR)  || (func == FN_SLT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                case (opc)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (r_func_ok)          state_d = S_R_EXEC;
                        else if (func == FN_JR) state_d = S_JR;
                        else                    state_d = S_HALT;
                    end
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                state_d   = (opc == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (func)
                    FN_SUB:  alu_op = 3'b110;
                    FN_AND:  alu_op = 3'b000;
                    FN_OR:   alu_op = 3'b001;
                    FN_SLT:  alu_op = 3'b111;
                    default: alu_op = 3'b010;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opc == OP_SLTI) ? 3'b111 : 3'b010;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b110;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        // Every final state shares the same exit: park in IDLE on a halt request.
        if (instr_done) state_d = halt_req ? S_IDLE : S_FETCH;
    end

    assign count_d     = instr_done ? count_q + CNT_W'(1) : count_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal     = (state_q == S_HALT);
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule
